// File: rtl/ascon_pkg.sv
// ---------------------------------------------------------------------------
// ascon_pkg
//   Shared types and constants for the Ascon S-box layer scheduler.
//   - state_e       : scheduler FSM states (IDLE / RUN / DONE)
//   - COL_W         : width of one S-box column (5 bits, x0..x4)
//   - ROW_W         : width of one S-box row write (4 entries x 5 bits)
//   - ROWS          : number of S-box rows (8 rows x 4 entries = 32 entries)
//   - NWORDS        : number of 64-bit state words
//   - ascon_state_t : 5-word Ascon state, x0 in word 0 (lowest bits)
// ---------------------------------------------------------------------------
package ascon_pkg;

   localparam int unsigned COL_W   = 5;
   localparam int unsigned ROW_W   = 20;
   localparam int unsigned ROWS    = 8;
   localparam int unsigned NWORDS  = 5;
   localparam int unsigned ASCON_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef logic [NWORDS-1:0][ASCON_W-1:0] ascon_state_t;

endpackage : ascon_pkg

// File: rtl/ascon_sbox_sched.sv
// ---------------------------------------------------------------------------
// ascon_sbox_sched
//   Applies a 5-bit S-box to every column of a 5-word state, one column per
//   clock, using an external 8x4x5 S-box with a combinational read port.
//   The S-box contents are rewritable one row (4 entries) at a time.
//
//   Optional feature (compile-time macro ASCON_SBOX_SCHED_STATS_EN):
//     defined   -> stat_layers_o counts completed output handshakes (wraps)
//     undefined -> stat_layers_o tied to 0, no counter present
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid_i/ready_o state-in handshake, in_state_i = {x4,..,x0}
//   out_valid_o/ready_i result handshake, out_state_o same packing
//   cfg_valid_i/ready_o S-box row write request (cfg_row_i, cfg_data_i)
//   flush_i            synchronous abort back to IDLE
//   sbox_update_o, sbox_addr_o, sbox_wdata_o, sbox_rdata_i  S-box port
//   stat_layers_o      completed-layer count
// ---------------------------------------------------------------------------
module ascon_sbox_sched
   import ascon_pkg::*;
#(
   parameter int unsigned NCOL = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,

   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [5*NCOL-1:0]    in_state_i,

   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [5*NCOL-1:0]    out_state_o,

   input  logic                 cfg_valid_i,
   output logic                 cfg_ready_o,
   input  logic [2:0]           cfg_row_i,
   input  logic [ROW_W-1:0]     cfg_data_i,

   input  logic                 flush_i,

   output logic                 sbox_update_o,
   output logic [COL_W-1:0]     sbox_addr_o,
   output logic [ROW_W-1:0]     sbox_wdata_o,
   input  logic [COL_W-1:0]     sbox_rdata_i,

   output logic [15:0]          stat_layers_o
);

   localparam int unsigned CNT_W = $clog2(NCOL);
   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NCOL - 1);

   typedef logic [NWORDS-1:0][NCOL-1:0] words_t;

   state_e           state_q;
   logic [CNT_W-1:0] col_q;
   words_t           src_q;
   words_t           res_q;
   logic             out_valid_q;

   logic             idle;
   logic             cfg_fire;
   logic             in_fire;
   logic [COL_W-1:0] col_addr;

   assign idle        = (state_q == ST_IDLE);
   assign cfg_ready_o = idle;
   assign in_ready_o  = idle && !cfg_valid_i;

   // rst_n gates the write strobe so that a request held during reset
   // never reaches the S-box; flush likewise suppresses the write.
   assign cfg_fire = idle && cfg_valid_i && rst_n && !flush_i;
   assign in_fire  = in_valid_i && in_ready_o;

   assign out_valid_o = out_valid_q;
   assign out_state_o = res_q;

   // Column address: x0 bit is the MSB of the S-box index.
   always_comb begin
      col_addr = '0;
      for (int unsigned w = 0; w < NWORDS; w++) begin
         col_addr[COL_W-1-w] = src_q[w][col_q];
      end
   end

   always_comb begin
      sbox_addr_o = '0;
      if (cfg_fire) begin
         sbox_addr_o = {cfg_row_i, 2'b00};
      end else if (state_q == ST_RUN) begin
         sbox_addr_o = col_addr;
      end
   end

   assign sbox_update_o = cfg_fire;
   assign sbox_wdata_o  = cfg_fire ? cfg_data_i : '0;

   // Scheduler FSM with registered out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         col_q       <= '0;
         src_q       <= '0;
         res_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (flush_i) begin
         state_q     <= ST_IDLE;
         col_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_fire) begin
                  src_q   <= in_state_i;
                  col_q   <= '0;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               for (int unsigned w = 0; w < NWORDS; w++) begin
                  res_q[w][col_q] <= sbox_rdata_i[COL_W-1-w];
               end
               if (col_q == LAST_COL) begin
                  state_q     <= ST_DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  col_q <= col_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready_i) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef ASCON_SBOX_SCHED_STATS_EN
   logic [15:0] stat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_q <= '0;
      end else if (!flush_i && out_valid_q && out_ready_i) begin
         stat_q <= stat_q + 16'd1;
      end
   end

   assign stat_layers_o = stat_q;
`else
   assign stat_layers_o = '0;
`endif

endmodule : ascon_sbox_sched
